// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one combinational ALU between two requesters.
// Operands are registered toward the ALU; result and flags are registered back.
module alu_arbiter #(
   parameter int BUS_WIDTH = 8,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [3:0]           req0_opcode,
   input  logic [BUS_WIDTH-1:0] req0_a,
   input  logic [BUS_WIDTH-1:0] req0_b,
   input  logic                 req0_cin,
   input  logic                 req0_bin,
   output logic                 rsp0_valid,
   input  logic                 rsp0_ready,
   output logic [BUS_WIDTH-1:0] rsp0_y,
   output logic [4:0]           rsp0_flags,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [3:0]           req1_opcode,
   input  logic [BUS_WIDTH-1:0] req1_a,
   input  logic [BUS_WIDTH-1:0] req1_b,
   input  logic                 req1_cin,
   input  logic                 req1_bin,
   output logic                 rsp1_valid,
   input  logic                 rsp1_ready,
   output logic [BUS_WIDTH-1:0] rsp1_y,
   output logic [4:0]           rsp1_flags,
   output logic [BUS_WIDTH-1:0] alu_a,
   output logic [BUS_WIDTH-1:0] alu_b,
   output logic [3:0]           alu_opcode,
   output logic                 alu_cin,
   output logic                 alu_bin,
   input  logic [BUS_WIDTH-1:0] alu_y,
   input  logic                 alu_cout,
   input  logic                 alu_bout,
   input  logic                 alu_zero,
   input  logic                 alu_par,
   input  logic                 alu_inv,
   output logic                 busy,
   output logic                 grant_id,
   output logic [CNT_WIDTH-1:0] inv_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_RESP
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic                   r_ptr;
   logic                   r_grant;
   logic [BUS_WIDTH-1:0]   r_a;
   logic [BUS_WIDTH-1:0]   r_b;
   logic [3:0]             r_op;
   logic                   r_cin;
   logic                   r_bin;
   logic [BUS_WIDTH-1:0]   r_y;
   logic [4:0]             r_flags;
   logic [CNT_WIDTH-1:0]   r_inv_cnt;

   logic                   w_any;
   logic                   w_win;
   logic                   w_acc;
   logic                   w_rsp_hs;

   assign w_any    = req0_valid | req1_valid;
   // Under contention the pointer decides; otherwise the lone requester wins.
   assign w_win    = (req0_valid & req1_valid) ? r_ptr : req1_valid;
   assign w_rsp_hs = r_grant ? rsp1_ready : rsp0_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w_acc  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (rst_n && w_any) begin
               w_acc  = 1'b1;
               w_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_next = S_RESP;
         end
         S_RESP: begin
            if (w_rsp_hs) begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr     <= 1'b0;
         r_grant   <= 1'b0;
         r_a       <= '0;
         r_b       <= '0;
         r_op      <= '0;
         r_cin     <= 1'b0;
         r_bin     <= 1'b0;
         r_y       <= '0;
         r_flags   <= '0;
         r_inv_cnt <= '0;
      end else begin
         if (w_acc) begin
            r_ptr   <= ~w_win;
            r_grant <= w_win;
            r_a     <= w_win ? req1_a      : req0_a;
            r_b     <= w_win ? req1_b      : req0_b;
            r_op    <= w_win ? req1_opcode : req0_opcode;
            r_cin   <= w_win ? req1_cin    : req0_cin;
            r_bin   <= w_win ? req1_bin    : req0_bin;
         end
         if (r_state == S_ISSUE) begin
            r_y     <= alu_y;
            r_flags <= {alu_inv, alu_par, alu_zero, alu_bout, alu_cout};
            if (alu_inv && (r_inv_cnt != {CNT_WIDTH{1'b1}})) begin
               r_inv_cnt <= r_inv_cnt + CNT_WIDTH'(1);
            end
         end
      end
   end

   assign req0_ready = w_acc & ~w_win;
   assign req1_ready = w_acc & w_win;

   assign rsp0_valid = (r_state == S_RESP) & ~r_grant;
   assign rsp1_valid = (r_state == S_RESP) & r_grant;
   assign rsp0_y     = rsp0_valid ? r_y : '0;
   assign rsp1_y     = rsp1_valid ? r_y : '0;
   assign rsp0_flags = rsp0_valid ? r_flags : '0;
   assign rsp1_flags = rsp1_valid ? r_flags : '0;

   assign alu_a      = r_a;
   assign alu_b      = r_b;
   assign alu_opcode = r_op;
   assign alu_cin    = r_cin;
   assign alu_bin    = r_bin;

   assign busy     = (r_state != S_IDLE);
   assign grant_id = r_grant;
   assign inv_cnt  = r_inv_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the alu_* side.
// Expected values are hand-computed constants.
module tb_alu_arbiter;

   logic       clk;
   logic       rst_n;
   logic       req0_valid, req0_ready, req0_cin, req0_bin;
   logic [3:0] req0_opcode;
   logic [7:0] req0_a, req0_b;
   logic       rsp0_valid, rsp0_ready;
   logic [7:0] rsp0_y;
   logic [4:0] rsp0_flags;
   logic       req1_valid, req1_ready, req1_cin, req1_bin;
   logic [3:0] req1_opcode;
   logic [7:0] req1_a, req1_b;
   logic       rsp1_valid, rsp1_ready;
   logic [7:0] rsp1_y;
   logic [4:0] rsp1_flags;
   logic [7:0] alu_a, alu_b, alu_y;
   logic [3:0] alu_opcode;
   logic       alu_cin, alu_bin, alu_cout, alu_bout;
   logic       alu_zero, alu_par, alu_inv;
   logic       busy, grant_id;
   logic [7:0] inv_cnt;
   logic [8:0] t;

   int n_chk;
   int n_err;

   alu_arbiter #(.BUS_WIDTH(8), .CNT_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_opcode(req0_opcode), .req0_a(req0_a), .req0_b(req0_b),
      .req0_cin(req0_cin), .req0_bin(req0_bin),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp0_y(rsp0_y), .rsp0_flags(rsp0_flags),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_opcode(req1_opcode), .req1_a(req1_a), .req1_b(req1_b),
      .req1_cin(req1_cin), .req1_bin(req1_bin),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp1_y(rsp1_y), .rsp1_flags(rsp1_flags),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_cin(alu_cin), .alu_bin(alu_bin),
      .alu_y(alu_y), .alu_cout(alu_cout), .alu_bout(alu_bout),
      .alu_zero(alu_zero), .alu_par(alu_par), .alu_inv(alu_inv),
      .busy(busy), .grant_id(grant_id), .inv_cnt(inv_cnt)
   );

   // 0 add, 1 sub, 2 and, 3 or, 4 xor, anything else invalid
   always_comb begin
      t        = '0;
      alu_y    = '0;
      alu_cout = 1'b0;
      alu_bout = 1'b0;
      alu_inv  = 1'b0;
      case (alu_opcode)
         4'd0: begin
            t        = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
            alu_y    = t[7:0];
            alu_cout = t[8];
         end
         4'd1: begin
            t        = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_bin};
            alu_y    = t[7:0];
            alu_bout = t[8];
         end
         4'd2: alu_y = alu_a & alu_b;
         4'd3: alu_y = alu_a | alu_b;
         4'd4: alu_y = alu_a ^ alu_b;
         default: alu_inv = 1'b1;
      endcase
      alu_zero = (alu_y == 8'd0);
      alu_par  = ^alu_y;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      req0_valid = 1'b1; req0_opcode = 4'd0; req0_a = 8'd0; req0_b = 8'd0;
      req0_cin = 1'b0; req0_bin = 1'b0; rsp0_ready = 1'b0;
      req1_valid = 1'b1; req1_opcode = 4'd0; req1_a = 8'd0; req1_b = 8'd0;
      req1_cin = 1'b0; req1_bin = 1'b0; rsp1_ready = 1'b0;

      // reset with both requesters valid
      tick();
      tick();
      chk("rst_rdy0", req0_ready, 0);
      chk("rst_rdy1", req1_ready, 0);
      chk("rst_rv0", rsp0_valid, 0);
      chk("rst_rv1", rsp1_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_inv", inv_cnt, 0);
      chk("rst_gnt", grant_id, 0);
      chk("rst_alua", alu_a, 0);

      // single add from requester 0
      req1_valid = 1'b0;
      req0_a = 8'h8F; req0_b = 8'h03; req0_opcode = 4'd0;
      rsp0_ready = 1'b1;
      rst_n = 1'b1;
      #1;
      chk("s_rdy0", req0_ready, 1);
      chk("s_rdy1", req1_ready, 0);
      tick();
      req0_valid = 1'b0;
      chk("s_busy", busy, 1);
      chk("s_gnt", grant_id, 0);
      chk("s_alua", alu_a, 8'h8F);
      chk("s_alub", alu_b, 8'h03);
      chk("s_rv0_c1", rsp0_valid, 0);
      tick();
      chk("s_rv0_c2", rsp0_valid, 1);
      chk("s_y", rsp0_y, 8'h92);
      chk("s_flags", rsp0_flags, 5'b01000);
      chk("s_rv1", rsp1_valid, 0);
      chk("s_rdy1_c2", req1_ready, 0);
      tick();
      chk("s_idle", busy, 0);
      chk("s_rv0_c3", rsp0_valid, 0);
      chk("s_y_clr", rsp0_y, 0);
      chk("s_hold", alu_a, 8'h8F);

      // contention from a fresh pointer
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req0_a = 8'h10; req0_b = 8'h20; req0_opcode = 4'd0; req0_cin = 1'b1;
      req1_a = 8'h03; req1_b = 8'h05; req1_opcode = 4'd1; req1_bin = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("c_rdy0", req0_ready, (k % 2 == 0));
         chk("c_rdy1", req1_ready, (k % 2 == 1));
         tick();
         chk("c_gnt", grant_id, k % 2);
         tick();
         if (k % 2 == 0) begin
            chk("c_rv0", rsp0_valid, 1);
            chk("c_y0", rsp0_y, 8'h31);
            chk("c_f0", rsp0_flags, 5'b01000);
         end else begin
            chk("c_rv1", rsp1_valid, 1);
            chk("c_y1", rsp1_y, 8'hFE);
            chk("c_f1", rsp1_flags, 5'b01010);
         end
         tick();
      end

      // backpressure on requester 1
      req0_valid = 1'b0;
      rsp1_ready = 1'b0;
      #1;
      chk("b_rdy1", req1_ready, 1);
      tick();
      req1_valid = 1'b0;
      req0_valid = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("b_rv1", rsp1_valid, 1);
         chk("b_y1", rsp1_y, 8'hFE);
         chk("b_rdy0", req0_ready, 0);
         tick();
      end
      rsp1_ready = 1'b1;
      #1;
      chk("b_rv1_last", rsp1_valid, 1);
      tick();
      chk("b_rv1_done", rsp1_valid, 0);
      chk("b_rdy0_go", req0_ready, 1);
      tick();
      req0_valid = 1'b0;
      chk("b_gnt0", grant_id, 0);
      tick();
      chk("b_y0", rsp0_y, 8'h31);
      tick();

      // invalid opcode and counter saturation
      req0_opcode = 4'hF; req0_a = 8'h01; req0_b = 8'h02;
      req0_valid = 1'b1;
      tick();
      tick();
      chk("i_flags", rsp0_flags, 5'b10100);
      chk("i_cnt1", inv_cnt, 1);
      tick();
      for (int i = 2; i <= 300; i++) begin
         tick();
         tick();
         if (i == 255) chk("i_cnt255", inv_cnt, 255);
         tick();
      end
      chk("i_sat", inv_cnt, 255);
      req0_valid = 1'b0;

      // reset while in ISSUE
      req0_opcode = 4'd0;
      req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      chk("r1_busy", busy, 0);
      chk("r1_inv", inv_cnt, 0);
      chk("r1_alua", alu_a, 0);
      rst_n = 1'b1;
      tick();
      tick();
      chk("r1_rv0", rsp0_valid, 0);
      chk("r1_rv1", rsp1_valid, 0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("r1_ptr0", req0_ready, 1);
      chk("r1_ptr1", req1_ready, 0);

      // reset while in RESP
      rsp0_ready = 1'b0;
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      chk("r2_rv0_pre", rsp0_valid, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("r2_rv0", rsp0_valid, 0);
      chk("r2_busy", busy, 0);
      tick();
      chk("r2_rv0_b", rsp0_valid, 0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("r2_ptr0", req0_ready, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
